// File: rtl/rate_cmd_pkg.sv
// Purpose: shared ASCII constants, rate codes and parser state encoding for rate_cmd_rx.
// Latency: n/a (declarations and pure helper functions only).
// Backpressure: n/a.
package rate_cmd_pkg;

  localparam logic [7:0] CH_R     = 8'h72;
  localparam logic [7:0] CH_A     = 8'h61;
  localparam logic [7:0] CH_T     = 8'h74;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_COLON = 8'h3A;
  localparam logic [7:0] CH_QUERY = 8'h3F;
  localparam logic [7:0] CH_1     = 8'h31;
  localparam logic [7:0] CH_5     = 8'h35;
  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_CR    = 8'h0D;

  localparam logic [1:0] RATE_1 = 2'b00;
  localparam logic [1:0] RATE_5 = 2'b01;
  localparam logic [1:0] RATE_A = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY,
    ST_VAL,
    ST_EOL,
    ST_QRY,
    ST_FLUSH
  } state_t;

  function automatic logic isTerm(input logic [7:0] b);
    return (b == CH_LF) || (b == CH_CR);
  endfunction

  // Expected byte at key position idx; 'r' (position 0) is consumed in IDLE.
  function automatic logic [7:0] keyChar(input logic [2:0] idx);
    case (idx)
      3'd1:    return CH_A;
      3'd2:    return CH_T;
      3'd3:    return CH_E;
      default: return CH_COLON;
    endcase
  endfunction

endpackage

// File: rtl/rate_cmd_rx_echo.sv
// Purpose: 1-entry valid/ready echo buffer copying every received byte (module rx_echo_buf).
// Latency: 1 cycle from iValid to oValid.
// Backpressure: holds oData while iReady=0; a byte arriving while full is dropped and oOvf pulses.
// Ports: clk, reset (async active-low), iData/iValid (byte strobe in),
//        oData/oValid/iReady (echo handshake out), oOvf (overflow pulse).
// Only compiled when RX_ECHO_EN is defined.
`ifdef RX_ECHO_EN
module rx_echo_buf (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iData,
  input  logic       iValid,
  output logic [7:0] oData,
  output logic       oValid,
  input  logic       iReady,
  output logic       oOvf
);

  logic xfer;
  assign xfer = oValid & iReady;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      oData  <= 8'hFF;
      oValid <= 1'b0;
      oOvf   <= 1'b0;
    end else begin
      oOvf <= 1'b0;
      if (iValid) begin
        // A draining transfer in the same cycle frees the slot for the new byte.
        if (!oValid || xfer) begin
          oData  <= iData;
          oValid <= 1'b1;
        end else begin
          oOvf <= 1'b1;
        end
      end else if (xfer) begin
        oValid <= 1'b0;
      end
    end
  end

endmodule
`endif

// File: rtl/rate_cmd_rx.sv
// Purpose: UART receive-side parser for "rate:<v>" and "?" lines; drives rate code and status/err pulses.
// Latency: 1 cycle from the iRX_VALID sample to every output change.
// Backpressure: none on the byte input (full-rate strobes); echo path uses valid/ready when RX_ECHO_EN.
// Ports: clk, reset (async active-low), iRX_DATA/iRX_VALID (byte in), oRATE/oRATE_UPDATE,
//        oSTATUS_REQ, oCMD_ERR, oBUSY; with RX_ECHO_EN also oECHO_DATA/oECHO_VALID/iECHO_READY/oECHO_OVF.
// Optional feature macro: RX_ECHO_EN.
module rate_cmd_rx
  import rate_cmd_pkg::*;
#(
  parameter int MAX_LINE    = 16,
  parameter int TIMEOUT_CYC = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] iRX_DATA,
  input  logic       iRX_VALID,
  output logic [1:0] oRATE,
  output logic       oRATE_UPDATE,
  output logic       oSTATUS_REQ,
  output logic       oCMD_ERR,
  output logic       oBUSY
`ifdef RX_ECHO_EN
  ,
  output logic [7:0] oECHO_DATA,
  output logic       oECHO_VALID,
  input  logic       iECHO_READY,
  output logic       oECHO_OVF
`endif
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LW = $clog2(MAX_LINE + 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [LW-1:0] LINE_MAX = LW'(MAX_LINE);

  state_t          state, stateNext;
  logic [2:0]      keyIdx, keyIdxNext;
  logic [1:0]      code, codeNext;
  logic [LW-1:0]   lineCnt, lineCntNext;
  logic [TW-1:0]   toCnt, toCntNext;
  logic [1:0]      rateNext;
  logic            updNext, stsNext, errNext;
  logic            term;

  assign term = isTerm(iRX_DATA);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      keyIdx       <= 3'd0;
      code         <= RATE_1;
      lineCnt      <= '0;
      toCnt        <= '0;
      oRATE        <= RATE_1;
      oRATE_UPDATE <= 1'b0;
      oSTATUS_REQ  <= 1'b0;
      oCMD_ERR     <= 1'b0;
      oBUSY        <= 1'b0;
    end else begin
      state        <= stateNext;
      keyIdx       <= keyIdxNext;
      code         <= codeNext;
      lineCnt      <= lineCntNext;
      toCnt        <= toCntNext;
      oRATE        <= rateNext;
      oRATE_UPDATE <= updNext;
      oSTATUS_REQ  <= stsNext;
      oCMD_ERR     <= errNext;
      oBUSY        <= (stateNext != ST_IDLE);
    end
  end

  always_comb begin
    stateNext   = state;
    keyIdxNext  = keyIdx;
    codeNext    = code;
    lineCntNext = lineCnt;
    toCntNext   = toCnt;
    rateNext    = oRATE;
    updNext     = 1'b0;
    stsNext     = 1'b0;
    errNext     = 1'b0;

    if (iRX_VALID) begin
      // A byte always restarts the idle timer, even on the cycle it would expire.
      toCntNext = '0;
      case (state)
        ST_IDLE: begin
          if (iRX_DATA == CH_R) begin
            stateNext  = ST_KEY;
            keyIdxNext = 3'd1;
          end else if (iRX_DATA == CH_QUERY) begin
            stateNext = ST_QRY;
          end else if (!term && iRX_DATA != CH_SPACE) begin
            stateNext = ST_FLUSH;
          end
        end
        ST_KEY: begin
          if (term) begin
            stateNext = ST_IDLE;
            errNext   = 1'b1;
          end else if (iRX_DATA == keyChar(keyIdx)) begin
            if (keyIdx == 3'd4) stateNext  = ST_VAL;
            else                keyIdxNext = keyIdx + 3'd1;
          end else begin
            stateNext = ST_FLUSH;
          end
        end
        ST_VAL: begin
          if (term) begin
            stateNext = ST_IDLE;
            errNext   = 1'b1;
          end else if (iRX_DATA == CH_1) begin
            codeNext  = RATE_1;
            stateNext = ST_EOL;
          end else if (iRX_DATA == CH_5) begin
            codeNext  = RATE_5;
            stateNext = ST_EOL;
          end else if (iRX_DATA == CH_A) begin
            codeNext  = RATE_A;
            stateNext = ST_EOL;
          end else begin
            stateNext = ST_FLUSH;
          end
        end
        ST_EOL: begin
          if (term) begin
            stateNext = ST_IDLE;
            rateNext  = code;
            updNext   = 1'b1;
          end else begin
            stateNext = ST_FLUSH;
          end
        end
        ST_QRY: begin
          if (term) begin
            stateNext = ST_IDLE;
            stsNext   = 1'b1;
          end else begin
            stateNext = ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (term) begin
            stateNext = ST_IDLE;
            errNext   = 1'b1;
          end
        end
        default: stateNext = ST_IDLE;
      endcase

      // Overlong line: a further non-terminator at the limit forces FLUSH; the count saturates.
      if (state != ST_IDLE && !term) begin
        if (lineCnt == LINE_MAX) stateNext   = ST_FLUSH;
        else                     lineCntNext = lineCnt + 1'b1;
      end
    end else if (state != ST_IDLE) begin
      if (toCnt == TO_LAST) begin
        stateNext = ST_IDLE;
        errNext   = 1'b1;
      end else begin
        toCntNext = toCnt + 1'b1;
      end
    end

    if (stateNext == ST_IDLE) begin
      lineCntNext = '0;
      toCntNext   = '0;
    end
  end

`ifdef RX_ECHO_EN
  rx_echo_buf u_echo (
    .clk    (clk),
    .reset  (reset),
    .iData  (iRX_DATA),
    .iValid (iRX_VALID),
    .oData  (oECHO_DATA),
    .oValid (oECHO_VALID),
    .iReady (iECHO_READY),
    .oOvf   (oECHO_OVF)
  );
`endif

endmodule

// File: tb/tb_rate_cmd_rx.sv
// Purpose: directed self-checking bench for rate_cmd_rx (small TIMEOUT_CYC for short runs).
// Latency: outputs are checked one cycle after the sampling edge of each byte.
// Backpressure: echo checks (RX_ECHO_EN builds only) hold iECHO_READY low to force overflow.
module tb_rate_cmd_rx;

  localparam int MAXL = 16;
  localparam int TOC  = 20;

  logic       clk;
  logic       reset;
  logic [7:0] iRX_DATA;
  logic       iRX_VALID;
  logic [1:0] oRATE;
  logic       oRATE_UPDATE;
  logic       oSTATUS_REQ;
  logic       oCMD_ERR;
  logic       oBUSY;
`ifdef RX_ECHO_EN
  logic [7:0] oECHO_DATA;
  logic       oECHO_VALID;
  logic       iECHO_READY;
  logic       oECHO_OVF;
`endif

  int errors = 0;
  int checks = 0;
  int updCnt = 0;
  int stsCnt = 0;
  int errCnt = 0;
  int exclViol = 0;

  rate_cmd_rx #(.MAX_LINE(MAXL), .TIMEOUT_CYC(TOC)) dut (
    .clk          (clk),
    .reset        (reset),
    .iRX_DATA     (iRX_DATA),
    .iRX_VALID    (iRX_VALID),
    .oRATE        (oRATE),
    .oRATE_UPDATE (oRATE_UPDATE),
    .oSTATUS_REQ  (oSTATUS_REQ),
    .oCMD_ERR     (oCMD_ERR),
    .oBUSY        (oBUSY)
`ifdef RX_ECHO_EN
    ,
    .oECHO_DATA   (oECHO_DATA),
    .oECHO_VALID  (oECHO_VALID),
    .iECHO_READY  (iECHO_READY),
    .oECHO_OVF    (oECHO_OVF)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse tally, sampled 2 time units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (oRATE_UPDATE) updCnt++;
    if (oSTATUS_REQ)  stsCnt++;
    if (oCMD_ERR)     errCnt++;
    if (int'(oRATE_UPDATE) + int'(oSTATUS_REQ) + int'(oCMD_ERR) > 1) exclViol++;
  end

  // Called at a falling edge; returns at the falling edge after the byte was sampled.
  task automatic sendByte(input logic [7:0] b);
    iRX_VALID = 1'b1;
    iRX_DATA  = b;
    @(negedge clk);
    iRX_VALID = 1'b0;
  endtask

  task automatic sendStr(input string s);
    for (int i = 0; i < s.len(); i++) sendByte(s[i]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    iRX_VALID = 1'b0;
    iRX_DATA = 8'h00;
`ifdef RX_ECHO_EN
    iECHO_READY = 1'b1;
`endif
    repeat (3) @(negedge clk);
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL reset_rate: got %b want 00", oRATE); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", oBUSY); end
    checks++; if ({oRATE_UPDATE, oSTATUS_REQ, oCMD_ERR} !== 3'b000)
      begin errors++; $display("FAIL reset_pulses: got %b want 000", {oRATE_UPDATE, oSTATUS_REQ, oCMD_ERR}); end
`ifdef RX_ECHO_EN
    checks++; if (oECHO_DATA !== 8'hFF) begin errors++; $display("FAIL reset_echo_data: got %h want ff", oECHO_DATA); end
    checks++; if (oECHO_VALID !== 1'b0) begin errors++; $display("FAIL reset_echo_valid: got %b want 0", oECHO_VALID); end
`endif
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_rate5;
    int u0;
    u0 = updCnt;
    sendStr("rate:5");
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL rate5_busy: got %b want 1", oBUSY); end
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL rate5_before: got %b want 00", oRATE); end
    sendByte(8'h0A);
    checks++; if (oRATE_UPDATE !== 1'b1) begin errors++; $display("FAIL rate5_upd: got %b want 1", oRATE_UPDATE); end
    checks++; if (oRATE !== 2'b01) begin errors++; $display("FAIL rate5_rate: got %b want 01", oRATE); end
    @(negedge clk);
    checks++; if (oRATE_UPDATE !== 1'b0) begin errors++; $display("FAIL rate5_upd_low: got %b want 0", oRATE_UPDATE); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL rate5_idle: got %b want 0", oBUSY); end
    @(negedge clk);
    checks++; if (updCnt - u0 !== 1) begin errors++; $display("FAIL rate5_upd_count: got %0d want 1", updCnt - u0); end
  endtask

  task automatic test_rate_a_then_1;
    int u0;
    u0 = updCnt;
    sendStr("rate:a");
    sendByte(8'h0D);
    checks++; if (oRATE !== 2'b11) begin errors++; $display("FAIL ratea_rate: got %b want 11", oRATE); end
    sendStr("rate:1\n");
    repeat (2) @(negedge clk);
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL rate1_rate: got %b want 00", oRATE); end
    checks++; if (updCnt - u0 !== 2) begin errors++; $display("FAIL ratea1_upd_count: got %0d want 2", updCnt - u0); end
  endtask

  task automatic test_bad_value;
    int u0, e0;
    sendStr("rate:5\n");
    @(negedge clk);
    u0 = updCnt; e0 = errCnt;
    sendStr("rate:7\n");
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) begin errors++; $display("FAIL bad_err_count: got %0d want 1", errCnt - e0); end
    checks++; if (updCnt - u0 !== 0) begin errors++; $display("FAIL bad_upd_count: got %0d want 0", updCnt - u0); end
    checks++; if (oRATE !== 2'b01) begin errors++; $display("FAIL bad_rate: got %b want 01", oRATE); end
  endtask

  task automatic test_query;
    int s0, e0;
    s0 = stsCnt; e0 = errCnt;
    sendByte(8'h3F);
    sendByte(8'h0A);
    checks++; if (oSTATUS_REQ !== 1'b1) begin errors++; $display("FAIL query_pulse: got %b want 1", oSTATUS_REQ); end
    repeat (2) @(negedge clk);
    checks++; if (stsCnt - s0 !== 1) begin errors++; $display("FAIL query_count: got %0d want 1", stsCnt - s0); end
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL query_err: got %0d want 0", errCnt - e0); end
    checks++; if (oRATE !== 2'b01) begin errors++; $display("FAIL query_rate: got %b want 01", oRATE); end
  endtask

  task automatic test_key_terminator;
    int e0;
    e0 = errCnt;
    sendStr("ra\n");
    checks++; if (oCMD_ERR !== 1'b1) begin errors++; $display("FAIL keyterm_pulse: got %b want 1", oCMD_ERR); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL keyterm_busy: got %b want 0", oBUSY); end
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) begin errors++; $display("FAIL keyterm_count: got %0d want 1", errCnt - e0); end
  endtask

  task automatic test_overlong;
    int e0;
    e0 = errCnt;
    for (int i = 0; i < 20; i++) sendByte(8'h78);
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL overlong_early: got %0d want 0", errCnt - e0); end
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL overlong_busy: got %b want 1", oBUSY); end
    sendByte(8'h0A);
    checks++; if (oCMD_ERR !== 1'b1) begin errors++; $display("FAIL overlong_pulse: got %b want 1", oCMD_ERR); end
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) begin errors++; $display("FAIL overlong_count: got %0d want 1", errCnt - e0); end
  endtask

  task automatic test_timeout;
    int e0;
    e0 = errCnt;
    sendStr("rat");
    repeat (15) @(negedge clk);
    checks++; if (oBUSY !== 1'b1) begin errors++; $display("FAIL timeout_early_busy: got %b want 1", oBUSY); end
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL timeout_early_err: got %0d want 0", errCnt - e0); end
    repeat (10) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) begin errors++; $display("FAIL timeout_err: got %0d want 1", errCnt - e0); end
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", oBUSY); end
    sendStr("rate:a\n");
    @(negedge clk);
    checks++; if (oRATE !== 2'b11) begin errors++; $display("FAIL timeout_recover: got %b want 11", oRATE); end
  endtask

  // A byte sampled on the exact expiry edge is processed and the timeout is dropped.
  task automatic test_timeout_race;
    int e0;
    e0 = errCnt;
    sendStr("rat");
    repeat (TOC - 1) @(negedge clk);
    sendStr("e:5\n");
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL race_err: got %0d want 0", errCnt - e0); end
    checks++; if (oRATE !== 2'b01) begin errors++; $display("FAIL race_rate: got %b want 01", oRATE); end
  endtask

  task automatic test_back_to_back;
    int u0, s0, e0;
    u0 = updCnt; s0 = stsCnt; e0 = errCnt;
    sendByte(8'h0D);
    sendStr("  rate:1\n?\n");
    repeat (2) @(negedge clk);
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL b2b_rate: got %b want 00", oRATE); end
    checks++; if (updCnt - u0 !== 1) begin errors++; $display("FAIL b2b_upd: got %0d want 1", updCnt - u0); end
    checks++; if (stsCnt - s0 !== 1) begin errors++; $display("FAIL b2b_sts: got %0d want 1", stsCnt - s0); end
    checks++; if (errCnt - e0 !== 0) begin errors++; $display("FAIL b2b_err: got %0d want 0", errCnt - e0); end
  endtask

  task automatic test_reset_midline;
    int e0;
    sendStr("rate:a\n");
    sendStr("rat");
    reset = 1'b0;
    @(negedge clk);
    checks++; if (oBUSY !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", oBUSY); end
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL midreset_rate: got %b want 00", oRATE); end
    reset = 1'b1;
    @(negedge clk);
    e0 = errCnt;
    sendStr("e:5\n");
    repeat (2) @(negedge clk);
    checks++; if (errCnt - e0 !== 1) begin errors++; $display("FAIL midreset_err: got %0d want 1", errCnt - e0); end
    checks++; if (oRATE !== 2'b00) begin errors++; $display("FAIL midreset_after: got %b want 00", oRATE); end
  endtask

`ifdef RX_ECHO_EN
  task automatic test_echo;
    @(negedge clk);
    iECHO_READY = 1'b0;
    sendByte(8'h72);
    checks++; if (oECHO_VALID !== 1'b1) begin errors++; $display("FAIL echo_valid: got %b want 1", oECHO_VALID); end
    checks++; if (oECHO_DATA !== 8'h72) begin errors++; $display("FAIL echo_data: got %h want 72", oECHO_DATA); end
    checks++; if (oECHO_OVF !== 1'b0) begin errors++; $display("FAIL echo_ovf_early: got %b want 0", oECHO_OVF); end
    sendByte(8'h61);
    checks++; if (oECHO_OVF !== 1'b1) begin errors++; $display("FAIL echo_ovf: got %b want 1", oECHO_OVF); end
    checks++; if (oECHO_DATA !== 8'h72) begin errors++; $display("FAIL echo_hold: got %h want 72", oECHO_DATA); end
    @(negedge clk);
    checks++; if (oECHO_OVF !== 1'b0) begin errors++; $display("FAIL echo_ovf_low: got %b want 0", oECHO_OVF); end
    iECHO_READY = 1'b1;
    @(negedge clk);
    checks++; if (oECHO_VALID !== 1'b0) begin errors++; $display("FAIL echo_drain: got %b want 0", oECHO_VALID); end
    sendByte(8'h0A);
    checks++; if (oECHO_DATA !== 8'h0A) begin errors++; $display("FAIL echo_lf: got %h want 0a", oECHO_DATA); end
    repeat (2) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_rate5();
    test_rate_a_then_1();
    test_bad_value();
    test_query();
    test_key_terminator();
    test_overlong();
    test_timeout();
    test_timeout_race();
    test_back_to_back();
    test_reset_midline();
`ifdef RX_ECHO_EN
    test_echo();
`endif
    checks++; if (exclViol !== 0) begin errors++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", exclViol); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
